// File: rtl/line_fifo_if.sv
// rtl/line_fifo_if.sv - line_fifo port bundle: inputCtrl write side, Cal read/retire side, status
interface line_fifo_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11,
  parameter int BUFFER_SIZE   = 3
);
  logic [DATA_WIDTH-1:0]    dIn;
  logic                     dInEn;
  logic [ADDRESS_WIDTH-1:0] ramAddrIn;
  logic                     lineEnd;
  logic                     frameStart;
  logic                     jmp1;
  logic                     jmp2;
  logic [ADDRESS_WIDTH-1:0] ramRdAddr00;
  logic [ADDRESS_WIDTH-1:0] ramRdAddr01;
  logic [ADDRESS_WIDTH-1:0] ramRdAddr10;
  logic [ADDRESS_WIDTH-1:0] ramRdAddr11;
  logic [DATA_WIDTH-1:0]    ramData00;
  logic [DATA_WIDTH-1:0]    ramData01;
  logic [DATA_WIDTH-1:0]    ramData10;
  logic [DATA_WIDTH-1:0]    ramData11;
  logic [BUFFER_SIZE-1:0]   fifoNum;
  logic                     full;
  logic                     overflow;

  modport slave (
    input  dIn, dInEn, ramAddrIn, lineEnd, frameStart, jmp1, jmp2,
    input  ramRdAddr00, ramRdAddr01, ramRdAddr10, ramRdAddr11,
    output ramData00, ramData01, ramData10, ramData11,
    output fifoNum, full, overflow
  );

  modport master (
    output dIn, dInEn, ramAddrIn, lineEnd, frameStart, jmp1, jmp2,
    output ramRdAddr00, ramRdAddr01, ramRdAddr10, ramRdAddr11,
    input  ramData00, ramData01, ramData10, ramData11,
    input  fifoNum, full, overflow
  );
endinterface

// File: rtl/line_fifo.sv
// rtl/line_fifo.sv - ring of line RAMs between inputCtrl and Cal with four registered read ports
module line_fifo #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11,
  parameter int BUFFER_SIZE   = 3,
  parameter int LINE_NUM      = 4,
  parameter int LINE_LEN      = 1024
) (
  input logic          clk,
  input logic          rst,
  line_fifo_if.slave   bus
);
  localparam int PTR_W = $clog2(LINE_NUM);
  localparam int LA_W  = $clog2(LINE_LEN);
  localparam logic [PTR_W+1:0]       LN_P     = (PTR_W+2)'(LINE_NUM);
  localparam logic [ADDRESS_WIDTH:0] LEN_P    = (ADDRESS_WIDTH+1)'(LINE_LEN);
  localparam logic [BUFFER_SIZE-1:0] FULL_CNT = BUFFER_SIZE'(LINE_NUM-1);
  localparam logic [BUFFER_SIZE-1:0] TWO_CNT  = BUFFER_SIZE'(2);

  logic [DATA_WIDTH-1:0] r_mem [LINE_NUM][LINE_LEN];

  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [BUFFER_SIZE-1:0] r_count;
  logic                   r_full;
  logic                   r_overflow;
  logic [DATA_WIDTH-1:0]  r_data00, r_data01, r_data10, r_data11;

  logic [1:0]             w_pop;
  logic [BUFFER_SIZE-1:0] w_pop_ext;
  logic [BUFFER_SIZE-1:0] w_eff_pop;
  logic [BUFFER_SIZE-1:0] w_after_pop;
  logic                   w_accept;
  logic [BUFFER_SIZE-1:0] w_next_count;
  logic [PTR_W-1:0]       w_line1;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [PTR_W+1:0] s;
    s = {2'b00, p} + {{PTR_W{1'b0}}, n};
    if (s >= LN_P) s = s - LN_P;
    return s[PTR_W-1:0];
  endfunction

  function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
    return {1'b0, a} < LEN_P;
  endfunction

  // jmp2 has priority; never retire more lines than are complete
  assign w_pop        = bus.jmp2 ? 2'd2 : (bus.jmp1 ? 2'd1 : 2'd0);
  assign w_pop_ext    = BUFFER_SIZE'(w_pop);
  assign w_eff_pop    = (r_count < w_pop_ext) ? r_count : w_pop_ext;
  assign w_after_pop  = r_count - w_eff_pop;
  assign w_accept     = bus.lineEnd && (w_after_pop < FULL_CNT);
  assign w_next_count = w_after_pop + BUFFER_SIZE'(w_accept);
  // With fewer than two lines, the second row replicates the bottom line
  assign w_line1      = (r_count < TWO_CNT) ? r_rd_ptr : ptr_add(r_rd_ptr, 2'd1);

  always_ff @(posedge clk) begin
    if (bus.dInEn && addr_ok(bus.ramAddrIn))
      r_mem[r_wr_ptr][bus.ramAddrIn[LA_W-1:0]] <= bus.dIn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_data00   <= '0;
      r_data01   <= '0;
      r_data10   <= '0;
      r_data11   <= '0;
    end else begin
      r_data00 <= addr_ok(bus.ramRdAddr00) ? r_mem[r_rd_ptr][bus.ramRdAddr00[LA_W-1:0]] : '0;
      r_data01 <= addr_ok(bus.ramRdAddr01) ? r_mem[r_rd_ptr][bus.ramRdAddr01[LA_W-1:0]] : '0;
      r_data10 <= addr_ok(bus.ramRdAddr10) ? r_mem[w_line1][bus.ramRdAddr10[LA_W-1:0]] : '0;
      r_data11 <= addr_ok(bus.ramRdAddr11) ? r_mem[w_line1][bus.ramRdAddr11[LA_W-1:0]] : '0;
      if (bus.frameStart) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_full     <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        r_rd_ptr <= ptr_add(r_rd_ptr, w_eff_pop[1:0]);
        r_count  <= w_next_count;
        r_full   <= (w_next_count == FULL_CNT);
        if (w_accept)
          r_wr_ptr <= ptr_add(r_wr_ptr, 2'd1);
        else if (bus.lineEnd)
          r_overflow <= 1'b1;
      end
    end
  end

  assign bus.ramData00 = r_data00;
  assign bus.ramData01 = r_data01;
  assign bus.ramData10 = r_data10;
  assign bus.ramData11 = r_data11;
  assign bus.fifoNum   = r_count;
  assign bus.full      = r_full;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_line_fifo.sv
// tb/tb_line_fifo.sv - directed self-checking bench for line_fifo
module tb_line_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;

  line_fifo_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(11), .BUFFER_SIZE(3)) bus ();

  line_fifo #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(11), .BUFFER_SIZE(3), .LINE_NUM(4), .LINE_LEN(1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      bus.ramAddrIn = 11'(i);
      bus.dIn       = base + 16'(i);
      bus.dInEn     = 1'b1;
      tick();
    end
    bus.dInEn = 1'b0;
  endtask

  task automatic pulse_line_end();
    bus.lineEnd = 1'b1;
    tick();
    bus.lineEnd = 1'b0;
  endtask

  initial begin
    bus.dIn = '0; bus.dInEn = 0; bus.ramAddrIn = '0; bus.lineEnd = 0;
    bus.frameStart = 0; bus.jmp1 = 0; bus.jmp2 = 0;
    bus.ramRdAddr00 = 11'd3; bus.ramRdAddr01 = 11'd0;
    bus.ramRdAddr10 = 11'd3; bus.ramRdAddr11 = 11'd6;
    tick(); tick();
    check("reset_fifoNum", 32'(bus.fifoNum), 0);
    check("reset_full", 32'(bus.full), 0);
    check("reset_overflow", 32'(bus.overflow), 0);
    check("reset_data00", 32'(bus.ramData00), 0);
    rst = 1'b0;
    tick();

    // two lines in slots 0 and 1
    write_line(16'h1000); pulse_line_end();
    write_line(16'h2000); pulse_line_end();
    check("t1_fifoNum", 32'(bus.fifoNum), 2);
    tick();
    check("t1_data00", 32'(bus.ramData00), 32'h1003);
    check("t1_data10", 32'(bus.ramData10), 32'h2003);
    check("t1_data11", 32'(bus.ramData11), 32'h2006);

    // retire one and complete one in the same cycle
    write_line(16'h3000);
    bus.jmp1 = 1'b1; bus.lineEnd = 1'b1;
    tick();
    bus.jmp1 = 1'b0; bus.lineEnd = 1'b0;
    check("t2_fifoNum", 32'(bus.fifoNum), 2);
    tick();
    check("t2_data00", 32'(bus.ramData00), 32'h2003);
    check("t2_data10", 32'(bus.ramData10), 32'h3003);

    // fill to three, then a dropped lineEnd
    write_line(16'h4000); pulse_line_end();
    check("t3_fifoNum_full", 32'(bus.fifoNum), 3);
    check("t3_full", 32'(bus.full), 1);
    check("t3_overflow_clear", 32'(bus.overflow), 0);
    write_line(16'h5000); pulse_line_end();
    check("t3_fifoNum_hold", 32'(bus.fifoNum), 3);
    check("t3_overflow_set", 32'(bus.overflow), 1);
    bus.jmp2 = 1'b1; tick(); bus.jmp2 = 1'b0;
    check("t3_fifoNum_jmp2", 32'(bus.fifoNum), 1);
    check("t3_full_clear", 32'(bus.full), 0);

    // single line: bottom-edge replication, then jmp2 clamps to 1
    bus.ramRdAddr00 = 11'd5; bus.ramRdAddr10 = 11'd5;
    tick();
    check("t4_data00", 32'(bus.ramData00), 32'h4005);
    check("t4_data10_repl", 32'(bus.ramData10), 32'h4005);
    bus.jmp2 = 1'b1; tick(); bus.jmp2 = 1'b0;
    check("t4_fifoNum", 32'(bus.fifoNum), 0);
    tick();
    check("t4_rdptr_plus1", 32'(bus.ramData00), 32'h5005);

    // read-first on the shared slot while empty
    bus.ramAddrIn = 11'd5; bus.dIn = 16'hABCD; bus.dInEn = 1'b1;
    tick();
    bus.dInEn = 1'b0;
    check("rdw_old", 32'(bus.ramData00), 32'h5005);
    tick();
    check("rdw_new", 32'(bus.ramData00), 32'hABCD);

    // out-of-range read address
    bus.ramRdAddr01 = 11'd7; tick();
    check("t5_data01_in", 32'(bus.ramData01), 32'h5007);
    bus.ramRdAddr01 = 11'd1024; tick();
    check("t5_data01_oor", 32'(bus.ramData01), 0);
    pulse_line_end(); pulse_line_end(); pulse_line_end();
    check("t5_fifoNum3", 32'(bus.fifoNum), 3);
    bus.jmp1 = 1'b1; bus.jmp2 = 1'b1; tick(); bus.jmp1 = 1'b0; bus.jmp2 = 1'b0;
    check("t5_fifoNum_both", 32'(bus.fifoNum), 1);

    // frameStart overrides lineEnd/jmp1
    pulse_line_end();
    check("t6_fifoNum2", 32'(bus.fifoNum), 2);
    check("t6_overflow_sticky", 32'(bus.overflow), 1);
    bus.frameStart = 1'b1; bus.lineEnd = 1'b1; bus.jmp1 = 1'b1;
    tick();
    bus.frameStart = 1'b0; bus.lineEnd = 1'b0; bus.jmp1 = 1'b0;
    check("t6_fifoNum", 32'(bus.fifoNum), 0);
    check("t6_full", 32'(bus.full), 0);
    check("t6_overflow", 32'(bus.overflow), 0);
    tick();
    check("t6_rdptr0", 32'(bus.ramData00), 32'hABCD);

    // asynchronous reset mid-line
    pulse_line_end();
    check("t6_fifoNum1", 32'(bus.fifoNum), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_fifoNum", 32'(bus.fifoNum), 0);
    check("arst_data00", 32'(bus.ramData00), 0);
    check("arst_overflow", 32'(bus.overflow), 0);
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
